// File: rtl/bcd_xs3_pkg.sv
// -----------------------------------------------------------------------------
// bcd_xs3_pkg
// Shared types and constants for the serial BCD <-> Excess-3 converter.
//   state_e     : controller states (IDLE / CONV / DONE)
//   DIGIT_W     : width of one decimal digit
//   XS3_OFFSET  : the Excess-3 bias added (BCD->XS3) or removed (XS3->BCD)
//   BCD_MAX     : largest legal BCD digit
//   XS3_MIN/MAX : legal Excess-3 digit range
//   cnt_width() : digit-counter width, never zero even for a one-digit word
// -----------------------------------------------------------------------------
package bcd_xs3_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int         DIGIT_W    = 4;
    localparam logic [3:0] XS3_OFFSET = 4'd3;
    localparam logic [3:0] BCD_MAX    = 4'd9;
    localparam logic [3:0] XS3_MIN    = 4'd3;
    localparam logic [3:0] XS3_MAX    = 4'd12;

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bcd_xs3_serial_conv_if.sv
// -----------------------------------------------------------------------------
// bcd_xs3_serial_conv_if
// Word-level valid/ready handshake for the serial converter.
//   in_valid/in_ready/in_data    : upstream word, digit 0 in bits [3:0]
//   out_valid/out_ready/out_data : converted word, same packing
//   err                          : invalid-digit flag, qualified by out_valid
// Modports:
//   master : the side that supplies words and consumes results
//   slave  : the converter
// -----------------------------------------------------------------------------
interface bcd_xs3_serial_conv_if
    import bcd_xs3_pkg::*;
#(
    parameter int DIGITS = 4
);

    logic                        in_valid;
    logic                        in_ready;
    logic [DIGITS*DIGIT_W-1:0]   in_data;
    logic                        out_valid;
    logic                        out_ready;
    logic [DIGITS*DIGIT_W-1:0]   out_data;
    logic                        err;

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  err
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output err
    );

endinterface

// File: rtl/bcd_xs3_digit.sv
// -----------------------------------------------------------------------------
// bcd_xs3_digit
// Combinational single-digit converter, time-multiplexed by the top level.
//   DIR       : 0 = BCD -> Excess-3 (add 3), 1 = Excess-3 -> BCD (subtract 3)
//   digit_in  : digit to convert
//   digit_out : converted digit, 4-bit wrap, computed for every input value
//   digit_ok  : digit_in lies in the legal range for the selected direction
// Build option: BCD_XS3_INVALID_DETECT_EN enables the range comparators;
// without it digit_ok is a constant 1 and no comparison logic exists.
// -----------------------------------------------------------------------------
module bcd_xs3_digit
    import bcd_xs3_pkg::*;
#(
    parameter int DIR = 0
) (
    input  logic [DIGIT_W-1:0] digit_in,
    output logic [DIGIT_W-1:0] digit_out,
    output logic               digit_ok
);

    // The 4-bit result width gives the mod-16 wrap for free (D+3 -> 0, 1-3 -> E).
    if (DIR == 0) begin : g_to_xs3
        assign digit_out = digit_in + XS3_OFFSET;
    end else begin : g_to_bcd
        assign digit_out = digit_in - XS3_OFFSET;
    end

`ifdef BCD_XS3_INVALID_DETECT_EN
    if (DIR == 0) begin : g_ok_bcd
        assign digit_ok = (digit_in <= BCD_MAX);
    end else begin : g_ok_xs3
        assign digit_ok = (digit_in >= XS3_MIN) && (digit_in <= XS3_MAX);
    end
`else
    assign digit_ok = 1'b1;
`endif

endmodule

// File: rtl/bcd_xs3_serial_conv.sv
// -----------------------------------------------------------------------------
// bcd_xs3_serial_conv
// Serial BCD <-> Excess-3 word converter. A word is accepted in IDLE, one
// digit per cycle is converted in CONV (digit 0 first) through a single
// bcd_xs3_digit instance, and the result is presented in DONE until taken.
// Latency is DIGITS cycles from the accept edge to out_valid; with out_ready
// held high one word completes every DIGITS+2 cycles.
// Parameters:
//   DIGITS : decimal digits per word (1..16)
//   DIR    : 0 = BCD -> Excess-3, 1 = Excess-3 -> BCD
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : slave side of bcd_xs3_serial_conv_if (in_*, out_*, err)
//   busy   : high whenever the controller is not in IDLE
// Build option: BCD_XS3_INVALID_DETECT_EN makes err the OR of digit validity
// failures over the word (cleared on accept); otherwise err is tied low.
// -----------------------------------------------------------------------------
module bcd_xs3_serial_conv
    import bcd_xs3_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int DIR    = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    bcd_xs3_serial_conv_if.slave   bus,
    output logic                   busy
);

    localparam int DATA_W = DIGITS * DIGIT_W;
    localparam int CNT_W  = cnt_width(DIGITS);

    state_e              state_q,    state_d;
    logic [CNT_W-1:0]    cnt_q,      cnt_d;
    logic [DATA_W-1:0]   data_q,     data_d;
    logic [DATA_W-1:0]   res_q,      res_d;
    logic                ready_en_q, ready_en_d;
`ifdef BCD_XS3_INVALID_DETECT_EN
    logic                err_q,      err_d;
`endif

    logic [DIGIT_W-1:0]  digit_cur;
    logic [DIGIT_W-1:0]  digit_conv;
    logic                digit_ok;
    logic                accept;
    logic                last_digit;

    bcd_xs3_digit #(
        .DIR (DIR)
    ) u_digit (
        .digit_in  (digit_cur),
        .digit_out (digit_conv),
        .digit_ok  (digit_ok)
    );

    // NOTE: ready_en_q is held low by reset and sets on the first edge after
    // release, so in_ready stays low in reset without depending on rst_n
    // combinationally.
    assign bus.in_ready  = (state_q == IDLE) && ready_en_q;
    assign bus.out_valid = (state_q == DONE);
    assign bus.out_data  = res_q;
    assign busy          = (state_q != IDLE);

`ifdef BCD_XS3_INVALID_DETECT_EN
    assign bus.err = err_q;
`else
    logic unused_digit_ok;
    assign unused_digit_ok = digit_ok;
    assign bus.err         = 1'b0;
`endif

    assign accept     = bus.in_valid && bus.in_ready;
    assign last_digit = (cnt_q == CNT_W'(DIGITS - 1));

    // Digit mux: constant-index selects keep the multiplexer shape obvious.
    always_comb begin
        digit_cur = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (cnt_q == CNT_W'(i)) begin
                digit_cur = data_q[i*DIGIT_W +: DIGIT_W];
            end
        end
    end

    // NOTE: every signal written here gets its hold value first; a path that
    // leaves one unassigned would infer a latch.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        data_d     = data_q;
        res_d      = res_q;
        ready_en_d = 1'b1;
`ifdef BCD_XS3_INVALID_DETECT_EN
        err_d      = err_q;
`endif

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    data_d  = bus.in_data;
                    cnt_d   = '0;
                    res_d   = '0;
`ifdef BCD_XS3_INVALID_DETECT_EN
                    err_d   = 1'b0;
`endif
                    state_d = CONV;
                end
            end

            CONV: begin
                for (int i = 0; i < DIGITS; i++) begin
                    if (cnt_q == CNT_W'(i)) begin
                        res_d[i*DIGIT_W +: DIGIT_W] = digit_conv;
                    end
                end
`ifdef BCD_XS3_INVALID_DETECT_EN
                err_d = err_q | ~digit_ok;
`endif
                if (last_digit) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            data_q     <= '0;
            res_q      <= '0;
            ready_en_q <= 1'b0;
`ifdef BCD_XS3_INVALID_DETECT_EN
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            data_q     <= data_d;
            res_q      <= res_d;
            ready_en_q <= ready_en_d;
`ifdef BCD_XS3_INVALID_DETECT_EN
            err_q      <= err_d;
`endif
        end
    end

endmodule

// File: tb/tb_bcd_xs3_serial_conv.sv
// -----------------------------------------------------------------------------
// tb_bcd_xs3_serial_conv
// Self-checking bench: a 4-digit BCD->XS3 instance, a 4-digit XS3->BCD
// instance and a 1-digit BCD->XS3 instance share clk/rst_n. Expected words
// are pushed to a scoreboard at the accept edge and popped when the DUT
// hands a result over. Honours BCD_XS3_INVALID_DETECT_EN for expected err.
// -----------------------------------------------------------------------------
module tb_bcd_xs3_serial_conv;

`ifdef BCD_XS3_INVALID_DETECT_EN
    localparam bit DETECT = 1'b1;
`else
    localparam bit DETECT = 1'b0;
`endif

    typedef struct {
        int          sel;
        logic [15:0] din;
        logic [15:0] dout;
        logic        raw_err;
    } vec_t;

    typedef struct {
        int          sel;
        logic [15:0] dout;
        logic        err;
    } exp_t;

    logic clk;
    logic rst_n;
    logic busy0, busy1, busy2;

    int n_cmp;
    int n_bad;
    int unsigned cyc_cnt;

    exp_t sb_q[$];
    vec_t vecs[10];

    bcd_xs3_serial_conv_if #(.DIGITS(4)) if0 ();
    bcd_xs3_serial_conv_if #(.DIGITS(4)) if1 ();
    bcd_xs3_serial_conv_if #(.DIGITS(1)) if2 ();

    bcd_xs3_serial_conv #(.DIGITS(4), .DIR(0)) dut0 (
        .clk (clk), .rst_n (rst_n), .bus (if0), .busy (busy0)
    );
    bcd_xs3_serial_conv #(.DIGITS(4), .DIR(1)) dut1 (
        .clk (clk), .rst_n (rst_n), .bus (if1), .busy (busy1)
    );
    bcd_xs3_serial_conv #(.DIGITS(1), .DIR(0)) dut2 (
        .clk (clk), .rst_n (rst_n), .bus (if2), .busy (busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic pop_check(input int sel, input logic [15:0] dout, input logic err);
        exp_t e;
        check("sb_nonempty", (sb_q.size() > 0) ? 32'd1 : 32'd0, 32'd1);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("sb_sel", sel, e.sel);
            check("sb_data", {16'h0, dout}, {16'h0, e.dout});
            check("sb_err", {31'h0, err}, {31'h0, e.err});
        end
    endtask

    // Result monitor: a transfer completes at the edge following a negedge
    // where out_valid and out_ready are both high.
    always @(negedge clk) begin
        if (rst_n && if0.out_valid && if0.out_ready) pop_check(0, if0.out_data, if0.err);
        if (rst_n && if1.out_valid && if1.out_ready) pop_check(1, if1.out_data, if1.err);
    end

    function automatic logic rdy(input int sel);
        return (sel == 0) ? if0.in_ready : if1.in_ready;
    endfunction

    function automatic logic ov(input int sel);
        return (sel == 0) ? if0.out_valid : if1.out_valid;
    endfunction

    task automatic drive(input int sel, input logic v, input logic [15:0] d);
        if (sel == 0) begin
            if0.in_valid = v;
            if0.in_data  = d;
        end else begin
            if1.in_valid = v;
            if1.in_data  = d;
        end
    endtask

    // Entered and left #1 after a rising edge.
    task automatic apply(input int sel, input logic [15:0] din,
                         input logic [15:0] dout, input logic exp_err);
        int n;
        n = 0;
        while (!rdy(sel) && n < 50) begin
            @(posedge clk); #1; n++;
        end
        check("in_ready_wait", {31'h0, rdy(sel)}, 32'd1);
        drive(sel, 1'b1, din);
        @(posedge clk);
        sb_q.push_back(exp_t'{sel, dout, exp_err});
        #1;
        drive(sel, 1'b0, din);
        n = 0;
        while (!ov(sel) && n < 50) begin
            @(posedge clk); #1; n++;
        end
        check("latency", n, 4);
    endtask

    initial begin
        int n;
        int n_acc;
        int unsigned acc_cyc[2];

        n_cmp   = 0;
        n_bad   = 0;
        cyc_cnt = 0;

        vecs[0] = '{0, 16'h1234, 16'h4567, 1'b0};
        vecs[1] = '{0, 16'h0987, 16'h3CBA, 1'b0};
        vecs[2] = '{0, 16'h9000, 16'hC333, 1'b0};
        vecs[3] = '{0, 16'h12A4, 16'h45D7, 1'b1};
        vecs[4] = '{0, 16'hDEF0, 16'h0123, 1'b1};
        vecs[5] = '{0, 16'h000A, 16'h333D, 1'b1};
        vecs[6] = '{1, 16'h4567, 16'h1234, 1'b0};
        vecs[7] = '{1, 16'h3CCC, 16'h0999, 1'b0};
        vecs[8] = '{1, 16'h4521, 16'h12FE, 1'b1};
        vecs[9] = '{1, 16'hD002, 16'hADDF, 1'b1};

        rst_n         = 1'b0;
        if0.in_valid  = 1'b0; if0.in_data = '0; if0.out_ready = 1'b1;
        if1.in_valid  = 1'b0; if1.in_data = '0; if1.out_ready = 1'b1;
        if2.in_valid  = 1'b0; if2.in_data = '0; if2.out_ready = 1'b1;

        // Reset state.
        #1;
        check("rst_in_ready",  {31'h0, if0.in_ready},  32'd0);
        check("rst_out_valid", {31'h0, if0.out_valid}, 32'd0);
        check("rst_out_data",  {16'h0, if0.out_data},  32'd0);
        check("rst_err",       {31'h0, if0.err},       32'd0);
        check("rst_busy",      {31'h0, busy0},         32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rel_in_ready_pre", {31'h0, if0.in_ready}, 32'd0);
        @(posedge clk); #1;
        check("rel_in_ready_post", {31'h0, if0.in_ready}, 32'd1);

        // Table-driven words on both directions.
        for (int i = 0; i < 10; i++) begin
            apply(vecs[i].sel, vecs[i].din, vecs[i].dout, DETECT & vecs[i].raw_err);
        end

        // Back-to-back words with in_valid held high: accepts DIGITS+2 apart.
        @(posedge clk); #1;
        if0.in_valid = 1'b1;
        if0.in_data  = 16'h9999;
        n_acc = 0;
        n = 0;
        while (n_acc < 2 && n < 40) begin
            @(negedge clk);
            n++;
            if (if0.in_ready) begin
                acc_cyc[n_acc] = cyc_cnt;
                sb_q.push_back(exp_t'{0, (n_acc == 0) ? 16'hCCCC : 16'h3333, 1'b0});
                n_acc++;
                @(posedge clk); #1;
                if (n_acc == 1) if0.in_data = 16'h0000;
                else            if0.in_valid = 1'b0;
            end
        end
        check("b2b_accepts", n_acc, 2);
        if (n_acc == 2) check("b2b_period", acc_cyc[1] - acc_cyc[0], 6);

        // Stall in DONE for 5 cycles.
        n = 0;
        while (busy0 && n < 20) begin
            @(posedge clk); #1; n++;
        end
        if0.out_ready = 1'b0;
        apply(0, 16'h2468, 16'h579B, 1'b0);
        repeat (5) begin
            @(posedge clk); #1;
            check("stall_valid",    {31'h0, if0.out_valid}, 32'd1);
            check("stall_data",     {16'h0, if0.out_data},  32'h579B);
            check("stall_err",      {31'h0, if0.err},       32'd0);
            check("stall_in_ready", {31'h0, if0.in_ready},  32'd0);
        end
        if0.out_ready = 1'b1;
        @(posedge clk); #1;
        check("stall_release_valid", {31'h0, if0.out_valid}, 32'd0);
        @(posedge clk); #1;
        check("post_xfer_in_ready", {31'h0, if0.in_ready}, 32'd1);

        // Reset while converting digit 2: word discarded, nothing queued.
        if0.in_valid = 1'b1;
        if0.in_data  = 16'h1234;
        @(posedge clk); #1;
        if0.in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3;
        check("mid_busy", {31'h0, busy0}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid",    {31'h0, if0.out_valid}, 32'd0);
        check("mid_rst_data",     {16'h0, if0.out_data},  32'd0);
        check("mid_rst_err",      {31'h0, if0.err},       32'd0);
        check("mid_rst_busy",     {31'h0, busy0},         32'd0);
        check("mid_rst_in_ready", {31'h0, if0.in_ready},  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("mid_rel_in_ready_pre", {31'h0, if0.in_ready}, 32'd0);
        @(posedge clk); #1;
        check("mid_rel_in_ready_post", {31'h0, if0.in_ready}, 32'd1);
        repeat (6) @(posedge clk);
        #1;
        check("mid_rst_no_output", {31'h0, if0.out_valid}, 32'd0);
        apply(0, 16'h0505, 16'h3838, 1'b0);

        // One-digit instance: exactly one cycle in CONV, wrap D -> 0.
        @(posedge clk); #1;
        check("d1_in_ready", {31'h0, if2.in_ready}, 32'd1);
        if2.in_valid = 1'b1;
        if2.in_data  = 4'hD;
        @(posedge clk); #1;
        if2.in_valid = 1'b0;
        check("d1_conv_busy",  {31'h0, busy2},         32'd1);
        check("d1_conv_valid", {31'h0, if2.out_valid}, 32'd0);
        @(posedge clk); #1;
        check("d1_done_valid", {31'h0, if2.out_valid}, 32'd1);
        check("d1_done_data",  {28'h0, if2.out_data},  32'h0);
        check("d1_done_err",   {31'h0, if2.err},       {31'h0, DETECT});
        check("d1_done_ready", {31'h0, if2.in_ready},  32'd0);
        @(posedge clk); #1;
        check("d1_idle_valid", {31'h0, if2.out_valid}, 32'd0);
        check("d1_idle_busy",  {31'h0, busy2},         32'd0);
        check("d1_idle_ready", {31'h0, if2.in_ready},  32'd1);

        // Drain the scoreboard.
        n = 0;
        while (sb_q.size() != 0 && n < 100) begin
            @(posedge clk); n++;
        end
        check("sb_drain", sb_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
